compare_debounce_fsm: RTL and testbench
=======================================

// Module: compare_debounce_fsm
// PURPOSE
//  Consumes the per-sample GT/LT/EQ flags of the N-bit magnitude comparator
//  (registered, with in_valid) and turns them into a debounced relation
//  state. The state changes only after DEBOUNCE consecutive valid samples
//  agree. Emits a one-cycle change pulse and a malformed-input error pulse.
//  Optionally keeps saturating per-class event counters.
// PARAMETERS
//  DEBOUNCE  3   consecutive agreeing samples needed to switch state (>=1)
//  CNT_W     16  width of each statistics counter (>=2)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      gt/lt/eq carry a sample this cycle
//  gt         in   1      A>B flag from the comparator
//  lt         in   1      A<B flag
//  eq         in   1      A==B flag
//  stat_clr   in   1      synchronous clear of counters (only with STATS_EN)
//  state      out  2      debounced relation: 00 UNK, 01 GT, 10 LT, 11 EQ
//  changed    out  1      one-cycle pulse; state took a new value this cycle
//  err        out  1      one-cycle pulse; in_valid with flags not one-hot
//  gt_cnt     out  CNT_W  accepted GT samples, saturating (STATS_EN only)
//  lt_cnt     out  CNT_W  accepted LT samples, saturating (STATS_EN only)
//  eq_cnt     out  CNT_W  accepted EQ samples, saturating (STATS_EN only)
// BEHAVIOUR
//  - Reset (async): state=UNK, changed=0, err=0, cand=UNK, run=0, cnts=0.
//  - Sample class s = {GT,LT,EQ} when exactly one flag is set.
//  - Internal: cand (2b) = candidate class; run = agreeing-sample count,
//    width $clog2(DEBOUNCE+1).
//  - in_valid=0: all registers hold. changed and err drop to 0.
//  - Valid, s==state: cand<=state, run<=0. No pulse.
//  - Valid, s!=state, s==cand: if run+1==DEBOUNCE then state<=s, changed<=1,
//    run<=0. Otherwise run<=run+1.
//  - Valid, s!=state, s!=cand: cand<=s, run<=1. If DEBOUNCE==1, switch
//    immediately: state<=s, changed<=1, run<=0.
//  - Valid, not one-hot (0, 2 or 3 flags set): err<=1, cand<=UNK, run<=0.
//    state is unchanged and no counter increments.
//  - UNK is never re-entered except by reset. From UNK the first run of
//    DEBOUNCE samples selects GT, LT or EQ.
//  - Latency: state/changed update on the clock edge that registers the
//    DEBOUNCE-th agreeing sample, so they are visible the following cycle.
//  - Outputs are registered; changed and err are never high for 2 cycles
//    from a single sample.
//  - Reset asserted mid-run discards cand/run; there is no partial carry-over.
// CONFIGURATION
//  - Macro COMPARE_DEBOUNCE_FSM_STATS_EN.
//  - Defined: the three counters count accepted one-hot samples and
//    saturate at all-ones. stat_clr zeroes them. If stat_clr and a sample
//    arrive in the same cycle, the sampled class counter becomes 1 and the
//    others become 0.
//  - Undefined: no counter logic. gt_cnt/lt_cnt/eq_cnt are tied to 0.
//    stat_clr is ignored.
// STRUCTURE
//  - Shared package compare_pkg: rel_t 2-bit state encoding localparams
//    (REL_UNK/GT/LT/EQ) and the function classify(gt,lt,eq) -> {ok, rel_t}.
//    The comparator and its other consumers reuse the same package.
//  - Sub-module sat_counter #(W): inc, clr, q. Instantiated three times
//    under the macro.
// TESTING (DEBOUNCE=3, CNT_W=4 unless noted)
//  1 Reset then 3 valid GT -> state 00 for 3 cycles, then 01 with changed=1
//    for exactly 1 cycle.
//  2 In state GT: LT,LT,GT,LT,LT -> state stays 01, no changed pulse
//    (run broken by the GT sample).
//  3 In state GT: LT,idle,idle,LT,LT -> state 10 after the 3rd LT.
//    Gaps in in_valid do not break a run.
//  4 Valid with gt=lt=1 mid-run (EQ,EQ,bad,EQ) -> err=1 for 1 cycle, state
//    unchanged; 3 more EQ are then needed.
//  5 STATS_EN: 20 GT samples -> gt_cnt=15 (saturated). stat_clr together
//    with an LT sample -> gt=0, lt=1, eq=0.
//  6 DEBOUNCE=1: GT,LT,EQ on consecutive cycles -> state follows each
//    sample, with changed high on 3 consecutive cycles. Assert async rst
//    mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/compare_pkg.sv
// compare_pkg: relation encoding and flag classifier shared by the comparator and its consumers
//   rel_t    : 2-bit relation, 00 UNK, 01 GT, 10 LT, 11 EQ
//   cls_t    : {ok, rel} result of classify
//   classify : maps gt/lt/eq flags to a relation, ok only when exactly one flag is set
package compare_pkg;
   typedef enum logic [1:0] {REL_UNK = 2'b00, REL_GT = 2'b01, REL_LT = 2'b10, REL_EQ = 2'b11} rel_t;
   typedef struct packed {
      logic ok;
      rel_t rel;
   } cls_t;
   function automatic cls_t classify(input logic gt, input logic lt, input logic eq);
      logic ok;
      ok = {gt, lt, eq} inside {3'b100, 3'b010, 3'b001};
      return '{ok: ok, rel: !ok ? REL_UNK : gt ? REL_GT : lt ? REL_LT : REL_EQ};
   endfunction
endpackage

// File: rtl/compare_debounce_fsm_if.sv
// compare_debounce_fsm_if: sample and status bundle of the debounced comparator FSM
//   master : drives in_valid, gt, lt, eq, stat_clr; observes state, changed, err, counters
//   slave  : the FSM side, the reverse directions
interface compare_debounce_fsm_if #(parameter int CNT_W = 16);
   logic             in_valid, gt, lt, eq, stat_clr;
   logic [1:0]       state;
   logic             changed, err;
   logic [CNT_W-1:0] gt_cnt, lt_cnt, eq_cnt;
   modport master (output in_valid, gt, lt, eq, stat_clr,
                   input  state, changed, err, gt_cnt, lt_cnt, eq_cnt);
   modport slave  (input  in_valid, gt, lt, eq, stat_clr,
                   output state, changed, err, gt_cnt, lt_cnt, eq_cnt);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that saturates at all-ones
//   clk, rst : clock and asynchronous active-high reset
//   inc      : count one event this cycle
//   clr      : synchronous clear; an event in the same cycle leaves the count at 1
//   q        : current count
module sat_counter #(parameter int W = 16) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (clr) q <= {{(W-1){1'b0}}, inc};
      else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/compare_debounce_fsm.sv
// compare_debounce_fsm: debounces comparator gt/lt/eq flags into a stable relation state
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of compare_debounce_fsm_if
//              in: in_valid, gt, lt, eq, stat_clr  out: state, changed, err, gt/lt/eq_cnt
//   DEBOUNCE : consecutive agreeing valid samples needed to switch state (>=1)
//   CNT_W    : statistics counter width (>=2), must match the interface
//   COMPARE_DEBOUNCE_FSM_STATS_EN : when defined, saturating per-class sample counters;
//              otherwise counters read 0 and stat_clr is ignored
module compare_debounce_fsm
   import compare_pkg::*;
#(
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 16
) (
   input logic                   clk,
   input logic                   rst,
   compare_debounce_fsm_if.slave bus
);
   localparam int RW = $clog2(DEBOUNCE + 1);
   rel_t          state, cand;
   logic [RW-1:0] run;
   logic          changed, err;
   cls_t          c;
   assign c = classify(bus.gt, bus.lt, bus.eq);
   // cand/run track the class trying to displace state; a sample matching state
   // or a malformed sample abandons the attempt, idle cycles leave it intact
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= REL_UNK;
         cand    <= REL_UNK;
         run     <= '0;
         changed <= 1'b0;
         err     <= 1'b0;
      end else begin
         changed <= 1'b0;
         err     <= 1'b0;
         if (bus.in_valid) begin
            if (!c.ok) begin
               err  <= 1'b1;
               cand <= REL_UNK;
               run  <= '0;
            end else if (c.rel == state) begin
               cand <= state;
               run  <= '0;
            end else if (c.rel == cand) begin
               if (32'(run) + 1 == DEBOUNCE) begin
                  state   <= c.rel;
                  changed <= 1'b1;
                  run     <= '0;
               end else run <= run + 1'b1;
            end else if (DEBOUNCE == 1) begin
               cand    <= c.rel;
               state   <= c.rel;
               changed <= 1'b1;
               run     <= '0;
            end else begin
               cand <= c.rel;
               run  <= RW'(1);
            end
         end
      end
   assign bus.state   = state;
   assign bus.changed = changed;
   assign bus.err     = err;
`ifdef COMPARE_DEBOUNCE_FSM_STATS_EN
   logic acc;
   assign acc = bus.in_valid && c.ok;
   sat_counter #(.W(CNT_W)) u_gt (.clk(clk), .rst(rst), .inc(acc && c.rel == REL_GT), .clr(bus.stat_clr), .q(bus.gt_cnt));
   sat_counter #(.W(CNT_W)) u_lt (.clk(clk), .rst(rst), .inc(acc && c.rel == REL_LT), .clr(bus.stat_clr), .q(bus.lt_cnt));
   sat_counter #(.W(CNT_W)) u_eq (.clk(clk), .rst(rst), .inc(acc && c.rel == REL_EQ), .clr(bus.stat_clr), .q(bus.eq_cnt));
`else
   logic unused_clr;
   assign unused_clr = bus.stat_clr;
   assign bus.gt_cnt = {CNT_W{1'b0}};
   assign bus.lt_cnt = {CNT_W{1'b0}};
   assign bus.eq_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_compare_debounce_fsm.sv
// tb_compare_debounce_fsm: directed scoreboard bench for DEBOUNCE=3 and DEBOUNCE=1 instances
module tb_compare_debounce_fsm;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
`ifdef COMPARE_DEBOUNCE_FSM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   compare_debounce_fsm_if #(.CNT_W(4)) b3 ();
   compare_debounce_fsm_if #(.CNT_W(4)) b1 ();
   compare_debounce_fsm #(.DEBOUNCE(3), .CNT_W(4)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
   compare_debounce_fsm #(.DEBOUNCE(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   typedef struct {
      string      tag;
      logic [1:0] st;
      logic       ch;
      logic       er;
   } exp_t;
   exp_t exp_q[$];
   int checks = 0;
   int passed = 0;
   int fails  = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask
   // d selects the instance (0: DEBOUNCE=3, 1: DEBOUNCE=1); the other one sees idle
   task automatic step(input bit d, input logic v, input logic g, input logic l, input logic e,
                       input logic clr, input logic [1:0] es, input logic ec, input logic ee,
                       input string tag);
      exp_t x;
      b3.in_valid = !d && v; b3.gt = g; b3.lt = l; b3.eq = e; b3.stat_clr = !d && clr;
      b1.in_valid = d && v;  b1.gt = g; b1.lt = l; b1.eq = e; b1.stat_clr = d && clr;
      exp_q.push_back('{tag, es, ec, ee});
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      chk({x.tag, ".state"},   d ? b1.state   : b3.state,   x.st);
      chk({x.tag, ".changed"}, d ? b1.changed : b3.changed, x.ch);
      chk({x.tag, ".err"},     d ? b1.err     : b3.err,     x.er);
      b3.in_valid = 1'b0; b3.stat_clr = 1'b0;
      b1.in_valid = 1'b0; b1.stat_clr = 1'b0;
   endtask
   initial begin
      b3.in_valid = 0; b3.gt = 0; b3.lt = 0; b3.eq = 0; b3.stat_clr = 0;
      b1.in_valid = 0; b1.gt = 0; b1.lt = 0; b1.eq = 0; b1.stat_clr = 0;
      #12;
      chk("rst.state", b3.state, 2'b00);
      chk("rst.changed", b3.changed, 0);
      chk("rst.err", b3.err, 0);
      chk("rst.gt_cnt", b3.gt_cnt, 0);
      chk("rst.state1", b1.state, 2'b00);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, "t1_gt1");
      step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, "t1_gt2");
      step(0, 1, 1, 0, 0, 0, 2'b01, 1, 0, "t1_gt3");
      step(0, 0, 0, 0, 0, 0, 2'b01, 0, 0, "t1_idle");
      step(0, 1, 0, 1, 0, 0, 2'b01, 0, 0, "t2_lt1");
      step(0, 1, 0, 1, 0, 0, 2'b01, 0, 0, "t2_lt2");
      step(0, 1, 1, 0, 0, 0, 2'b01, 0, 0, "t2_gt");
      step(0, 1, 0, 1, 0, 0, 2'b01, 0, 0, "t2_lt3");
      step(0, 1, 0, 1, 0, 0, 2'b01, 0, 0, "t2_lt4");
      step(0, 1, 1, 0, 0, 0, 2'b01, 0, 0, "t3_gt");
      step(0, 1, 0, 1, 0, 0, 2'b01, 0, 0, "t3_lt1");
      step(0, 0, 0, 1, 0, 0, 2'b01, 0, 0, "t3_idle1");
      step(0, 0, 0, 0, 0, 0, 2'b01, 0, 0, "t3_idle2");
      step(0, 1, 0, 1, 0, 0, 2'b01, 0, 0, "t3_lt2");
      step(0, 1, 0, 1, 0, 0, 2'b10, 1, 0, "t3_lt3");
      step(0, 1, 0, 0, 1, 0, 2'b10, 0, 0, "t4_eq1");
      step(0, 1, 0, 0, 1, 0, 2'b10, 0, 0, "t4_eq2");
      step(0, 1, 1, 1, 0, 0, 2'b10, 0, 1, "t4_bad");
      step(0, 1, 0, 0, 1, 0, 2'b10, 0, 0, "t4_eq3");
      step(0, 1, 0, 0, 1, 0, 2'b10, 0, 0, "t4_eq4");
      step(0, 1, 0, 0, 1, 0, 2'b11, 1, 0, "t4_eq5");
      step(0, 0, 0, 1, 1, 0, 2'b11, 0, 0, "t4_idle_junk");
      step(0, 1, 0, 0, 0, 0, 2'b11, 0, 1, "t4_none");
      step(0, 1, 1, 1, 1, 0, 2'b11, 0, 1, "t4_all");
      step(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, "t4_idle");
      step(0, 0, 0, 0, 0, 1, 2'b11, 0, 0, "t5_clr");
      chk("t5_clr.gt_cnt", b3.gt_cnt, 0);
      chk("t5_clr.eq_cnt", b3.eq_cnt, 0);
      for (int i = 0; i < 20; i++)
         step(0, 1, 1, 0, 0, 0, i < 2 ? 2'b11 : 2'b01, i == 2, 0, "t5_gt");
      chk("t5_sat.gt_cnt", b3.gt_cnt, STATS ? 15 : 0);
      step(0, 1, 0, 1, 0, 1, 2'b01, 0, 0, "t5_clr_lt");
      chk("t5_clr_lt.gt_cnt", b3.gt_cnt, 0);
      chk("t5_clr_lt.lt_cnt", b3.lt_cnt, STATS ? 1 : 0);
      chk("t5_clr_lt.eq_cnt", b3.eq_cnt, 0);
      step(1, 1, 1, 0, 0, 0, 2'b01, 1, 0, "t6_gt");
      step(1, 1, 0, 1, 0, 0, 2'b10, 1, 0, "t6_lt");
      step(1, 1, 0, 0, 1, 0, 2'b11, 1, 0, "t6_eq");
      step(1, 1, 0, 0, 0, 0, 2'b11, 0, 1, "t6_none");
      step(1, 1, 1, 0, 0, 0, 2'b01, 1, 0, "t6_gt2");
      #2 rst = 1'b1;
      #1;
      chk("t6_arst.state1", b1.state, 0);
      chk("t6_arst.changed1", b1.changed, 0);
      chk("t6_arst.state3", b3.state, 0);
      chk("t6_arst.lt_cnt", b3.lt_cnt, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      step(1, 1, 0, 1, 0, 0, 2'b10, 1, 0, "t6_after_rst");
      step(0, 1, 0, 1, 0, 0, 2'b00, 0, 0, "t6_d3_after_rst");
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
